// File: rtl/fp_accel_pkg.sv
// Shared types and width helpers for the ID-pair result path.
package fp_accel_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } pack_state_t;

   function automatic int pair_width(input int vec_id_width);
      return 2 * vec_id_width;
   endfunction

   function automatic int pairs_per_beat(input int bus_width, input int pair_w);
      return bus_width / pair_w;
   endfunction

   function automatic int keep_width(input int bus_width);
      return bus_width / 8;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the pointer, pointer follows the grant.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         en,
   input  logic         restart,
   output logic [N-1:0] grant
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] gnt_idx;
   logic          found;
   int            idx;

   always_comb begin
      grant   = '0;
      gnt_idx = ptr;
      found   = 1'b0;
      idx     = 0;
      for (int i = 1; i <= N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = en;
            gnt_idx    = PW'(idx);
         end
      end
   end

   // restart makes channel 0 the first winner of the next run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= PW'(N - 1);
      end else if (restart) begin
         ptr <= PW'(N - 1);
      end else if (en && found) begin
         ptr <= gnt_idx;
      end
   end

endmodule

// File: rtl/id_pair_axis_packer.sv
// Collects ID pairs from NUM_CH comparator pipelines and packs them into AXI-Stream beats.
// state    | meaning
// ST_RUN   | accepting pairs, full pack buffers go out as normal beats
// ST_FLUSH | all channels done; emit remaining pairs as the tlast beat, then restart
module id_pair_axis_packer
   import fp_accel_pkg::*;
#(
   parameter  int NUM_CH         = 4,
   parameter  int VEC_ID_WIDTH   = 8,
   parameter  int BUS_WIDTH      = 128,
   localparam int PAIR_WIDTH     = pair_width(VEC_ID_WIDTH),
   localparam int PAIRS_PER_BEAT = pairs_per_beat(BUS_WIDTH, PAIR_WIDTH),
   localparam int KEEP_WIDTH     = keep_width(BUS_WIDTH)
) (
   input  logic                         ap_clk,
   input  logic                         ap_rstn,
   input  logic [NUM_CH*PAIR_WIDTH-1:0] i_IDPair_Out,
   input  logic [NUM_CH-1:0]            i_IDPair_Ready,
   input  logic [NUM_CH-1:0]            i_IDPair_Last,
   input  logic [NUM_CH-1:0]            i_Ch_Done,
   output logic [NUM_CH-1:0]            o_IDPair_Read,
   output logic [BUS_WIDTH-1:0]         M_AXIS_ID_PAIR_tdata,
   output logic [KEEP_WIDTH-1:0]        M_AXIS_ID_PAIR_tkeep,
   output logic                         M_AXIS_ID_PAIR_tvalid,
   output logic                         M_AXIS_ID_PAIR_tlast,
   input  logic                         M_AXIS_ID_PAIR_tready
);
   localparam int FILL_W = $clog2(PAIRS_PER_BEAT + 1);
   localparam int BPP    = PAIR_WIDTH / 8;

   logic [NUM_CH-1:0]     done, done_nxt, req, grant;
   logic [FILL_W-1:0]     fill;
   logic [PAIR_WIDTH-1:0] slots [PAIRS_PER_BEAT];
   logic [PAIR_WIDTH-1:0] acc_pair;
   logic [BUS_WIDTH-1:0]  pack_data;
   logic [KEEP_WIDTH-1:0] pack_keep;
   pack_state_t           state;
   logic                  out_free, pack_full, accept_en, accept, xfer, restart;
   int                    wr_slot;

   assign out_free  = !M_AXIS_ID_PAIR_tvalid || M_AXIS_ID_PAIR_tready;
   assign pack_full = (fill == FILL_W'(PAIRS_PER_BEAT));
   // a full buffer may still accept when it empties into the output register this cycle
   assign accept_en = (state == ST_RUN) && (!pack_full || out_free);
   assign xfer      = out_free && ((state == ST_FLUSH) || pack_full);
   assign restart   = xfer && (state == ST_FLUSH);
   assign req       = i_IDPair_Ready & ~done;
   assign accept    = |grant;
   assign wr_slot   = xfer ? 0 : int'(fill);
   assign done_nxt  = done | i_Ch_Done | (grant & i_IDPair_Last);
   assign o_IDPair_Read = grant;

   rr_arbiter #(.N(NUM_CH)) u_arb (
      .clk     (ap_clk),
      .rst_n   (ap_rstn),
      .req     (req),
      .en      (accept_en),
      .restart (restart),
      .grant   (grant)
   );

   always_comb begin
      acc_pair = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (grant[c]) acc_pair = i_IDPair_Out[c*PAIR_WIDTH +: PAIR_WIDTH];
      end
   end

   // slots at or above fill hold stale pairs and are masked to zero
   always_comb begin
      pack_data = '0;
      pack_keep = '0;
      for (int s = 0; s < PAIRS_PER_BEAT; s++) begin
         if (s < int'(fill)) begin
            pack_data[s*PAIR_WIDTH +: PAIR_WIDTH] = slots[s];
            pack_keep[s*BPP +: BPP]               = '1;
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rstn) begin
      if (!ap_rstn) begin
         state                 <= ST_RUN;
         fill                  <= '0;
         done                  <= '0;
         for (int s = 0; s < PAIRS_PER_BEAT; s++) slots[s] <= '0;
         M_AXIS_ID_PAIR_tdata  <= '0;
         M_AXIS_ID_PAIR_tkeep  <= '0;
         M_AXIS_ID_PAIR_tlast  <= 1'b0;
         M_AXIS_ID_PAIR_tvalid <= 1'b0;
      end else begin
         if (xfer) begin
            M_AXIS_ID_PAIR_tdata  <= pack_data;
            M_AXIS_ID_PAIR_tkeep  <= pack_keep;
            M_AXIS_ID_PAIR_tlast  <= (state == ST_FLUSH);
            M_AXIS_ID_PAIR_tvalid <= 1'b1;
         end else if (M_AXIS_ID_PAIR_tready) begin
            M_AXIS_ID_PAIR_tvalid <= 1'b0;
         end
         for (int s = 0; s < PAIRS_PER_BEAT; s++) begin
            if (accept && (s == wr_slot)) slots[s] <= acc_pair;
         end
         case (state)
            ST_RUN: begin
               done <= done_nxt;
               if (accept) fill <= xfer ? FILL_W'(1) : fill + FILL_W'(1);
               else if (xfer) fill <= '0;
               if (&done_nxt) state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (xfer) begin
                  fill  <= '0;
                  done  <= '0;
                  state <= ST_RUN;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_id_pair_axis_packer.sv
// Directed bench for id_pair_axis_packer: per-scenario tasks with hand-computed beats.
module tb_id_pair_axis_packer;

   logic         ap_clk = 1'b0;
   logic         ap_rstn;
   logic [63:0]  pair_in;
   logic [3:0]   ready, last, ch_done, read;
   logic [127:0] tdata;
   logic [15:0]  tkeep;
   logic         tvalid, tlast, tready;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [15:0]  src_q [4][$];
   logic [3:0]   last_en;
   logic [3:0]   rd_s;

   logic [15:0]  acc_pair [$];
   int           acc_ch   [$];
   int           acc_cyc  [$];
   logic [127:0] bq_data  [$];
   logic [15:0]  bq_keep  [$];
   logic         bq_last  [$];
   int           bq_cyc   [$];

   id_pair_axis_packer dut (
      .ap_clk                (ap_clk),
      .ap_rstn               (ap_rstn),
      .i_IDPair_Out          (pair_in),
      .i_IDPair_Ready        (ready),
      .i_IDPair_Last         (last),
      .i_Ch_Done             (ch_done),
      .o_IDPair_Read         (read),
      .M_AXIS_ID_PAIR_tdata  (tdata),
      .M_AXIS_ID_PAIR_tkeep  (tkeep),
      .M_AXIS_ID_PAIR_tvalid (tvalid),
      .M_AXIS_ID_PAIR_tlast  (tlast),
      .M_AXIS_ID_PAIR_tready (tready)
   );

   always #5 ap_clk = ~ap_clk;

   function automatic logic [15:0] pv(input int c, input int k);
      return 16'((c << 8) | k);
   endfunction

   task automatic clear_logs();
      acc_pair.delete(); acc_ch.delete(); acc_cyc.delete();
      bq_data.delete(); bq_keep.delete(); bq_last.delete(); bq_cyc.delete();
      last_en = 4'b0000;
   endtask

   task automatic cycle(input logic [3:0] pulse);
      for (int c = 0; c < 4; c++) begin
         if (src_q[c].size() > 0) begin
            ready[c]            = 1'b1;
            pair_in[c*16 +: 16] = src_q[c][0];
            last[c]             = last_en[c] && (src_q[c].size() == 1);
         end else begin
            ready[c]            = 1'b0;
            pair_in[c*16 +: 16] = '0;
            last[c]             = 1'b0;
         end
      end
      ch_done = pulse;
      @(negedge ap_clk);
      rd_s = read;
      n_checks++;
      if (!$onehot0(rd_s) || ((rd_s & ~ready) != 4'b0)) begin
         n_fail++;
         $display("FAIL read_onehot: read=%b ready=%b", rd_s, ready);
      end
      if (tvalid && tready) begin
         bq_data.push_back(tdata); bq_keep.push_back(tkeep);
         bq_last.push_back(tlast); bq_cyc.push_back(cyc);
      end
      @(posedge ap_clk);
      cyc++;
      for (int c = 0; c < 4; c++) begin
         if (rd_s[c] && src_q[c].size() > 0) begin
            acc_pair.push_back(src_q[c].pop_front());
            acc_ch.push_back(c);
            acc_cyc.push_back(cyc);
         end
      end
      #1;
      ch_done = 4'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(4'b0000);
   endtask

   task automatic test_reset();
      ap_rstn = 1'b0; tready = 1'b1; pair_in = '0; ready = '0; last = '0; ch_done = '0;
      clear_logs();
      repeat (3) @(posedge ap_clk);
      #1;
      n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", tvalid); end
      n_checks++; if (tdata !== '0) begin n_fail++; $display("FAIL rst_tdata: got %h want 0", tdata); end
      n_checks++; if (tkeep !== '0) begin n_fail++; $display("FAIL rst_tkeep: got %h want 0", tkeep); end
      n_checks++; if (tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %b want 0", tlast); end
      ap_rstn = 1'b1;
      run(2);
      n_checks++; if (bq_data.size() != 0) begin n_fail++; $display("FAIL rst_idle_beats: got %0d want 0", bq_data.size()); end
   endtask

   task automatic test_single_channel();
      int j;
      clear_logs();
      for (int k = 1; k <= 8; k++) src_q[0].push_back(16'(k * 16'h0101));
      cycle(4'b1110);
      run(12);
      n_checks++; if (acc_pair.size() != 8) begin n_fail++; $display("FAIL single_count: got %0d want 8", acc_pair.size()); end
      n_checks++;
      if (bq_data.size() != 1) begin n_fail++; $display("FAIL single_beats: got %0d want 1", bq_data.size()); end
      else begin
         n_checks++; if (bq_data[0] !== 128'h0808_0707_0606_0505_0404_0303_0202_0101) begin n_fail++; $display("FAIL single_tdata: got %h", bq_data[0]); end
         n_checks++; if (bq_keep[0] !== 16'hFFFF) begin n_fail++; $display("FAIL single_tkeep: got %h want ffff", bq_keep[0]); end
         n_checks++; if (bq_last[0] !== 1'b0) begin n_fail++; $display("FAIL single_tlast: got %b want 0", bq_last[0]); end
         if (acc_cyc.size() == 8) begin
            n_checks++; if (bq_cyc[0] != acc_cyc[7] + 1) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", bq_cyc[0], acc_cyc[7] + 1); end
         end
      end
      cycle(4'b0001);
      j = cyc;
      run(4);
      n_checks++;
      if (bq_data.size() != 2) begin n_fail++; $display("FAIL single_flush_beats: got %0d want 2", bq_data.size()); end
      else begin
         n_checks++; if (bq_keep[1] !== 16'h0000 || bq_last[1] !== 1'b1 || bq_data[1] !== '0) begin
            n_fail++; $display("FAIL single_flush: keep=%h last=%b data=%h want 0000/1/0", bq_keep[1], bq_last[1], bq_data[1]); end
         n_checks++; if (bq_cyc[1] != j + 1) begin n_fail++; $display("FAIL single_flush_time: got %0d want %0d", bq_cyc[1], j + 1); end
      end
   endtask

   task automatic test_round_robin();
      logic [127:0] exp;
      clear_logs();
      for (int c = 0; c < 4; c++) for (int k = 0; k < 4; k++) src_q[c].push_back(pv(c, k));
      run(20);
      n_checks++;
      if (acc_ch.size() != 16) begin n_fail++; $display("FAIL rr_count: got %0d want 16", acc_ch.size()); end
      else begin
         for (int i = 0; i < 16; i++) begin
            n_checks++; if (acc_ch[i] != i % 4) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, acc_ch[i], i % 4); end
            n_checks++; if (acc_cyc[i] != acc_cyc[0] + i) begin n_fail++; $display("FAIL rr_rate[%0d]: got %0d want %0d", i, acc_cyc[i], acc_cyc[0] + i); end
         end
      end
      n_checks++;
      if (bq_data.size() != 2) begin n_fail++; $display("FAIL rr_beats: got %0d want 2", bq_data.size()); end
      else begin
         for (int b = 0; b < 2; b++) begin
            exp = '0;
            for (int s = 0; s < 8; s++) exp[s*16 +: 16] = pv(s % 4, b * 2 + s / 4);
            n_checks++; if (bq_data[b] !== exp || bq_keep[b] !== 16'hFFFF || bq_last[b] !== 1'b0) begin
               n_fail++; $display("FAIL rr_beat%0d: got %h/%h/%b want %h/ffff/0", b, bq_data[b], bq_keep[b], bq_last[b], exp); end
         end
      end
      cycle(4'b1111);
      run(4);
      n_checks++; if (bq_data.size() != 3 || bq_keep[bq_keep.size()-1] !== 16'h0 || bq_last[bq_last.size()-1] !== 1'b1) begin
         n_fail++; $display("FAIL rr_flush: beats=%0d want 3 with empty tlast", bq_data.size()); end
   endtask

   task automatic test_partial_flush();
      clear_logs();
      last_en = 4'b0011;
      src_q[0].push_back(pv(0, 1)); src_q[0].push_back(pv(0, 2));
      src_q[1].push_back(pv(1, 1));
      cycle(4'b1100);
      run(6);
      n_checks++;
      if (acc_ch.size() != 3) begin n_fail++; $display("FAIL part_count: got %0d want 3", acc_ch.size()); end
      else begin
         n_checks++; if (acc_ch[0] != 0 || acc_ch[1] != 1 || acc_ch[2] != 0) begin
            n_fail++; $display("FAIL part_order: got %0d,%0d,%0d want 0,1,0", acc_ch[0], acc_ch[1], acc_ch[2]); end
      end
      n_checks++;
      if (bq_data.size() != 1) begin n_fail++; $display("FAIL part_beats: got %0d want 1", bq_data.size()); end
      else begin
         n_checks++; if (bq_data[0] !== {80'h0, pv(0, 2), pv(1, 1), pv(0, 1)}) begin n_fail++; $display("FAIL part_tdata: got %h", bq_data[0]); end
         n_checks++; if (bq_keep[0] !== 16'h003F || bq_last[0] !== 1'b1) begin n_fail++; $display("FAIL part_keep_last: got %h/%b want 003f/1", bq_keep[0], bq_last[0]); end
         if (acc_cyc.size() == 3) begin
            n_checks++; if (bq_cyc[0] != acc_cyc[2] + 1) begin n_fail++; $display("FAIL part_time: got %0d want %0d", bq_cyc[0], acc_cyc[2] + 1); end
         end
      end
      clear_logs();
      last_en = 4'b0011;
      src_q[0].push_back(pv(0, 9));
      src_q[1].push_back(pv(1, 9));
      cycle(4'b1100);
      run(6);
      n_checks++; if (acc_ch.size() < 1 || acc_ch[0] != 0) begin n_fail++; $display("FAIL restart_ch0: first grant not channel 0 (%0d accepts)", acc_ch.size()); end
      n_checks++; if (bq_data.size() != 1 || bq_data[0] !== {96'h0, pv(1, 9), pv(0, 9)} || bq_keep[0] !== 16'h000F || bq_last[0] !== 1'b1) begin
         n_fail++; $display("FAIL restart_beat: beats=%0d want one 000f tlast beat", bq_data.size()); end
   endtask

   task automatic test_backpressure();
      logic [127:0] exp0;
      clear_logs();
      tready = 1'b0;
      for (int c = 0; c < 4; c++) for (int k = 0; k < 8; k++) src_q[c].push_back(pv(c, k));
      exp0 = '0;
      for (int s = 0; s < 8; s++) exp0[s*16 +: 16] = pv(s % 4, s / 4);
      run(20);
      n_checks++; if (acc_pair.size() != 16) begin n_fail++; $display("FAIL bp_count: got %0d want 16", acc_pair.size()); end
      n_checks++; if (rd_s !== 4'b0) begin n_fail++; $display("FAIL bp_read: got %b want 0000", rd_s); end
      n_checks++; if (tvalid !== 1'b1 || tdata !== exp0) begin n_fail++; $display("FAIL bp_hold: got %b/%h want 1/%h", tvalid, tdata, exp0); end
      run(3);
      n_checks++; if (acc_pair.size() != 16 || tdata !== exp0 || tkeep !== 16'hFFFF) begin
         n_fail++; $display("FAIL bp_stable: count=%0d tdata=%h", acc_pair.size(), tdata); end
      tready = 1'b1;
      run(30);
      cycle(4'b1111);
      run(4);
      n_checks++;
      if (acc_pair.size() != 32) begin n_fail++; $display("FAIL bp_total: got %0d want 32", acc_pair.size()); end
      else begin
         for (int i = 0; i < 32; i++) begin
            n_checks++; if (acc_pair[i] !== pv(i % 4, i / 4)) begin n_fail++; $display("FAIL bp_pair[%0d]: got %h want %h", i, acc_pair[i], pv(i % 4, i / 4)); end
         end
      end
      n_checks++;
      if (bq_data.size() != 5) begin n_fail++; $display("FAIL bp_beats: got %0d want 5", bq_data.size()); end
      else begin
         for (int b = 0; b < 4; b++) begin
            logic [127:0] exp;
            exp = '0;
            for (int s = 0; s < 8; s++) exp[s*16 +: 16] = pv(s % 4, b * 2 + s / 4);
            n_checks++; if (bq_data[b] !== exp || bq_keep[b] !== 16'hFFFF || bq_last[b] !== 1'b0) begin
               n_fail++; $display("FAIL bp_beat%0d: got %h want %h", b, bq_data[b], exp); end
         end
         n_checks++; if (bq_keep[4] !== 16'h0 || bq_last[4] !== 1'b1) begin n_fail++; $display("FAIL bp_last: got %h/%b want 0000/1", bq_keep[4], bq_last[4]); end
      end
   endtask

   task automatic test_done_only();
      int j;
      clear_logs();
      cycle(4'b1111);
      j = cyc;
      run(4);
      n_checks++;
      if (bq_data.size() != 1) begin n_fail++; $display("FAIL done_beats: got %0d want 1", bq_data.size()); end
      else begin
         n_checks++; if (bq_keep[0] !== 16'h0 || bq_last[0] !== 1'b1 || bq_data[0] !== '0) begin
            n_fail++; $display("FAIL done_beat: got %h/%b/%h want 0000/1/0", bq_keep[0], bq_last[0], bq_data[0]); end
         n_checks++; if (bq_cyc[0] != j + 1) begin n_fail++; $display("FAIL done_time: got %0d want %0d", bq_cyc[0], j + 1); end
      end
   endtask

   task automatic test_reset_mid();
      clear_logs();
      tready = 1'b0;
      for (int k = 1; k <= 13; k++) src_q[0].push_back(pv(0, k));
      run(15);
      n_checks++; if (acc_pair.size() != 13 || tvalid !== 1'b1) begin
         n_fail++; $display("FAIL mid_setup: count=%0d tvalid=%b want 13/1", acc_pair.size(), tvalid); end
      ap_rstn = 1'b0;
      #2;
      n_checks++; if (tvalid !== 1'b0 || tdata !== '0 || tkeep !== '0 || tlast !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_out: tvalid=%b tdata=%h tkeep=%h tlast=%b want all 0", tvalid, tdata, tkeep, tlast); end
      run(2);
      ap_rstn = 1'b1;
      tready = 1'b1;
      clear_logs();
      last_en = 4'b0001;
      src_q[0].push_back(pv(0, 8'hAA));
      cycle(4'b1110);
      run(6);
      n_checks++; if (bq_data.size() != 1 || bq_data[0] !== {112'h0, pv(0, 8'hAA)} || bq_keep[0] !== 16'h0003 || bq_last[0] !== 1'b1) begin
         n_fail++; $display("FAIL mid_post_run: beats=%0d want one beat 00aa/0003/tlast", bq_data.size()); end
   endtask

   initial begin
      test_reset();
      test_single_channel();
      test_round_robin();
      test_partial_flush();
      test_backpressure();
      test_done_only();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
